// File: rtl/emu_frame_sequencer.sv
// Frame sequencer between a byte-stream host link and an emulation wrapper: writes the stimulus
// bytes, loads them, gives the DUT one clock period, captures its outputs and streams them back.
module emu_frame_sequencer #(
  parameter int NUM_STIM = 2,
  parameter int NUM_OUT  = 4,
  parameter int HALF     = 2
) (
  input  logic        clk_emu,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  Din_emu,
  output logic [2:0]  Addr_emu,
  output logic        load_emu,
  output logic        get_emu,
  output logic        clk_dut,
  input  logic [7:0]  Dout_emu,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int              HW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [2:0]      LAST_STIM = 3'(NUM_STIM - 1);
  localparam logic [2:0]      LAST_OUT  = 3'(NUM_OUT - 1);
  localparam logic [HW-1:0]   LAST_HALF = HW'(HALF - 1);

  typedef enum logic [3:0] {
    RECV, WR, LOAD, CLKH, CLKL, GET, RADDR, RCAP, SEND
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [2:0]     j_q, j_d;
  logic [HW-1:0]  half_q, half_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]     din_q, din_d;
  logic [2:0]     addr_q, addr_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           load_q, load_d;
  logic           get_q, get_d;
  logic           clk_dut_q, clk_dut_d;

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      state_q     <= RECV;
      idx_q       <= '0;
      j_q         <= '0;
      half_q      <= '0;
      frame_cnt_q <= '0;
      din_q       <= '0;
      addr_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      load_q      <= 1'b0;
      get_q       <= 1'b0;
      clk_dut_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      half_q      <= half_d;
      frame_cnt_q <= frame_cnt_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      load_q      <= load_d;
      get_q       <= get_d;
      clk_dut_q   <= clk_dut_d;
    end
  end

  // In RECV rx_ready is 1, so rx_valid alone is the handshake; likewise tx_ready in SEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV:    if (rx_valid) state_d = WR;
      WR:      state_d = (idx_q == LAST_STIM) ? LOAD : RECV;
      LOAD:    state_d = CLKH;
      CLKH:    if (half_q == LAST_HALF) state_d = CLKL;
      CLKL:    if (half_q == LAST_HALF) state_d = GET;
      GET:     state_d = RADDR;
      RADDR:   state_d = RCAP;
      RCAP:    state_d = SEND;
      SEND:    if (tx_ready) state_d = (j_q == LAST_OUT) ? RECV : RADDR;
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    j_d         = j_q;
    half_d      = half_q;
    frame_cnt_d = frame_cnt_q;
    din_d       = din_q;
    addr_d      = addr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    unique case (state_q)
      RECV: begin
        if (rx_valid) begin
          din_d  = rx_data;
          addr_d = idx_q;
        end
      end
      WR:   idx_d = (idx_q == LAST_STIM) ? 3'd0 : idx_q + 3'd1;
      CLKH, CLKL: half_d = (half_q == LAST_HALF) ? '0 : half_q + 1'b1;
      GET: begin
        j_d    = 3'd0;
        addr_d = 3'd0;
      end
      RCAP: begin
        tx_data_d  = Dout_emu;
        tx_valid_d = 1'b1;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (j_q == LAST_OUT) begin
            j_d         = 3'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            j_d    = j_q + 3'd1;
            addr_d = j_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
    // Strobes are registered from the next state so they line up with the state they belong to.
    load_d    = (state_d == LOAD);
    get_d     = (state_d == GET);
    clk_dut_d = (state_d == CLKH);
  end

  assign rx_ready  = (state_q == RECV) && !reset;
  assign busy      = (state_q != RECV);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign Din_emu   = din_q;
  assign Addr_emu  = addr_q;
  assign load_emu  = load_q;
  assign get_emu   = get_q;
  assign clk_dut   = clk_dut_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_emu_frame_sequencer.sv
// Bench for emu_frame_sequencer: a behavioural emulation wrapper around a tiny DUT, table-driven
// frames, and hand-written sequences for reset, backpressure, counter wrap and HALF=1 latency.
module tb_emu_frame_sequencer;

  localparam int HALF_A = 2;

  logic        clk_emu = 1'b0;
  logic        reset;
  logic [7:0]  rx_data, tx_data, din_emu, dout_emu;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [2:0]  addr_emu;
  logic        load_emu, get_emu, clk_dut, busy;
  logic [15:0] frame_cnt;

  logic [7:0]  rx_data_b, tx_data_b, din_emu_b;
  logic        rx_valid_b, rx_ready_b, tx_valid_b, tx_ready_b;
  logic [2:0]  addr_emu_b;
  logic        load_emu_b, get_emu_b, clk_dut_b, busy_b;
  logic [15:0] frame_cnt_b;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_frames;

  always #5 clk_emu = ~clk_emu;

  emu_frame_sequencer #(.NUM_STIM(2), .NUM_OUT(4), .HALF(HALF_A)) dut_a (
    .clk_emu(clk_emu), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .Din_emu(din_emu), .Addr_emu(addr_emu), .load_emu(load_emu), .get_emu(get_emu),
    .clk_dut(clk_dut), .Dout_emu(dout_emu), .busy(busy), .frame_cnt(frame_cnt)
  );

  emu_frame_sequencer #(.NUM_STIM(2), .NUM_OUT(4), .HALF(1)) dut_b (
    .clk_emu(clk_emu), .reset(reset),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .Din_emu(din_emu_b), .Addr_emu(addr_emu_b), .load_emu(load_emu_b), .get_emu(get_emu_b),
    .clk_dut(clk_dut_b), .Dout_emu(8'h5A), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  // Wrapper model: the emulated DUT computes {b, ~a, a^b, a+b} on each rising clk_dut.
  logic [7:0] stim_mem [8];
  logic [7:0] out_mem [8];
  logic [7:0] q_reg [4];
  logic [7:0] in_a, in_b;
  logic       clk_dut_prev;

  always @(posedge clk_emu) begin
    if (!load_emu && !get_emu) stim_mem[addr_emu] <= din_emu;
    if (load_emu) begin
      in_a <= stim_mem[0];
      in_b <= stim_mem[1];
    end
    clk_dut_prev <= clk_dut;
    if (clk_dut && !clk_dut_prev) begin
      q_reg[0] <= in_a + in_b;
      q_reg[1] <= in_a ^ in_b;
      q_reg[2] <= ~in_a;
      q_reg[3] <= in_b;
    end
    if (get_emu) for (int k = 0; k < 4; k++) out_mem[k] <= q_reg[k];
    dout_emu <= out_mem[addr_emu];
  end

  typedef struct {
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [3:0][7:0] exp;
    int              stall_idx;
    bit              hold_valid;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sends b0/b1 and collects four bytes, checking WR contents, strobes, latency and the count.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [3:0][7:0] exp, input int stall_idx, input bit hold_valid);
    int sent = 0, got = 0, cyc = 0, hs_cyc = 0, stall_left = 5;
    int wr_pend = -1, load_cnt = 0, get_cnt = 0, hi_cnt = 0, lo_cnt = 0, rise_cnt = 0;
    int overlap = 0, extra_hs = 0, ready_bad = 0;
    bit seen_hi = 0, seen_get = 0, prev_clk = 0, lat_done = 0;
    logic [7:0] wr_byte = 8'h00;
    while (got < 4 && cyc < 200) begin
      @(negedge clk_emu);
      cyc++;
      if (wr_pend >= 0) begin
        check("wr_addr", 32'(addr_emu), 32'(wr_pend));
        check("wr_din", 32'(din_emu), 32'(wr_byte));
        check("wr_rx_ready", 32'(rx_ready), 32'd0);
        wr_pend = -1;
      end
      if (busy == rx_ready) ready_bad++;
      if (load_emu && get_emu) overlap++;
      if (load_emu) load_cnt++;
      if (get_emu) begin
        get_cnt++;
        seen_get = 1;
      end
      if (clk_dut) begin
        hi_cnt++;
        if (!prev_clk) rise_cnt++;
        seen_hi = 1;
      end else if (seen_hi && !seen_get) lo_cnt++;
      prev_clk = clk_dut;
      if (tx_valid && !lat_done) begin
        check("latency", 32'(cyc - hs_cyc), 32'(6 + 2 * HALF_A));
        lat_done = 1;
      end
      if (got == stall_idx && stall_left > 0 && (tx_valid || stall_left < 5)) begin
        tx_ready = 0;
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(exp[got]));
        stall_left--;
      end else if (tx_valid) begin
        check($sformatf("tx_byte%0d", got), 32'(tx_data), 32'(exp[got]));
        got++;
        tx_ready = 1;
      end else tx_ready = 1;
      if (sent < 2) begin
        rx_valid = 1;
        rx_data = (sent == 0) ? b0 : b1;
        if (rx_ready) begin
          wr_pend = sent;
          wr_byte = rx_data;
          sent++;
          if (sent == 2) hs_cyc = cyc;
        end
      end else if (hold_valid && got < 4) begin
        rx_valid = 1;
        rx_data = 8'h77;
        if (rx_ready) extra_hs++;
      end else rx_valid = 0;
    end
    check("tx_byte_count", 32'(got), 32'd4);
    @(negedge clk_emu);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("post_tx_valid", 32'(tx_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("load_pulses", 32'(load_cnt), 32'd1);
    check("get_pulses", 32'(get_cnt), 32'd1);
    check("clk_high_cycles", 32'(hi_cnt), 32'(HALF_A));
    check("clk_low_cycles", 32'(lo_cnt), 32'(HALF_A));
    check("clk_rises", 32'(rise_cnt), 32'd1);
    check("load_get_overlap", 32'(overlap), 32'd0);
    check("extra_rx_accepts", 32'(extra_hs), 32'd0);
    check("busy_vs_ready", 32'(ready_bad), 32'd0);
  endtask

  task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    int sent = 0, cyc = 0;
    while (sent < n && cyc < 50) begin
      @(negedge clk_emu);
      cyc++;
      rx_valid = 1;
      rx_data = (sent == 0) ? b0 : b1;
      if (rx_ready) sent++;
    end
    check("send_bytes_done", 32'(sent), 32'(n));
    @(negedge clk_emu);
    rx_valid = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(negedge clk_emu);
    reset = 0;
    #1;
  endtask

  task automatic run_half1_check();
    int sent = 0, cyc = 0, hs_cyc = 0, seen = 0, load_cnt = 0, get_cnt = 0, hi_cnt = 0;
    tx_ready_b = 1;
    while (sent < 2 && cyc < 50) begin
      @(negedge clk_emu);
      cyc++;
      if (sent == 1) begin
        check("b_wr_addr", 32'(addr_emu_b), 32'd0);
        check("b_wr_din", 32'(din_emu_b), 32'h11);
      end
      rx_valid_b = 1;
      rx_data_b = (sent == 0) ? 8'h11 : 8'h22;
      if (rx_ready_b) sent++;
    end
    hs_cyc = cyc;
    while (!tx_valid_b && cyc < hs_cyc + 40) begin
      @(negedge clk_emu);
      cyc++;
      rx_valid_b = 0;
      if (load_emu_b) load_cnt++;
      if (get_emu_b) get_cnt++;
      if (clk_dut_b) hi_cnt++;
    end
    check("b_latency", 32'(cyc - hs_cyc), 32'd8);
    check("b_load_pulses", 32'(load_cnt), 32'd1);
    check("b_get_pulses", 32'(get_cnt), 32'd1);
    check("b_clk_high_cycles", 32'(hi_cnt), 32'd1);
    hs_cyc = cyc;
    while (frame_cnt_b == 16'd0 && cyc < hs_cyc + 40) begin
      if (tx_valid_b) begin
        seen++;
        check("b_tx_data", 32'(tx_data_b), 32'h5A);
      end
      @(negedge clk_emu);
      cyc++;
    end
    check("b_tx_bytes", 32'(seen), 32'd4);
    check("b_frame_cnt", 32'(frame_cnt_b), 32'd1);
    check("b_busy", 32'(busy_b), 32'd0);
  endtask

  initial begin
    // exp packs bytes as {out3, out2, out1, out0}
    vecs[0] = '{8'h1B, 8'hA5, {8'hA5, 8'hE4, 8'hBE, 8'hC0}, -1, 1'b0};
    vecs[1] = '{8'h00, 8'h00, {8'h00, 8'hFF, 8'h00, 8'h00},  2, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, {8'h01, 8'h00, 8'hFE, 8'h00}, -1, 1'b1};
    vecs[3] = '{8'h80, 8'h80, {8'h80, 8'h7F, 8'h00, 8'h00}, -1, 1'b0};
    vecs[4] = '{8'h3C, 8'hC3, {8'hC3, 8'hC3, 8'hFF, 8'hFF}, -1, 1'b0};

    reset = 1;
    rx_valid = 0; rx_data = 8'h00; tx_ready = 0;
    rx_valid_b = 0; rx_data_b = 8'h00; tx_ready_b = 0;
    repeat (3) @(negedge clk_emu);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_strobes", 32'({load_emu, get_emu, clk_dut}), 32'd0);
    check("rst_addr_din", 32'({addr_emu, din_emu}), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_b_rx_ready", 32'(rx_ready_b), 32'd0);
    reset = 0;
    #1;
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    exp_frames = 16'd0;
    for (int v = 0; v < 5; v++) begin
      exp_frames = exp_frames + 16'd1;
      run_frame(vecs[v].b0, vecs[v].b1, vecs[v].exp, vecs[v].stall_idx, vecs[v].hold_valid);
    end

    // Reset while the DUT clock is high.
    send_bytes(2, 8'h12, 8'h34);
    begin
      int w = 0;
      while (!clk_dut && w < 30) begin
        @(negedge clk_emu);
        w++;
      end
      check("reached_clkh", 32'(clk_dut), 32'd1);
    end
    pulse_reset();
    check("clkh_rst_clk_dut", 32'(clk_dut), 32'd0);
    check("clkh_rst_busy", 32'(busy), 32'd0);
    check("clkh_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("clkh_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_frames = 16'd1;
    run_frame(vecs[3].b0, vecs[3].b1, vecs[3].exp, -1, 1'b0);

    // Reset after a partial stimulus: the next frame must start at address 0.
    send_bytes(1, 8'h55, 8'h00);
    pulse_reset();
    exp_frames = 16'd1;
    run_frame(vecs[4].b0, vecs[4].b1, vecs[4].exp, -1, 1'b0);

    // Reset while an output byte is pending.
    tx_ready = 0;
    send_bytes(2, 8'h9A, 8'hBC);
    begin
      int w = 0;
      while (!tx_valid && w < 40) begin
        @(negedge clk_emu);
        w++;
      end
      check("pending_tx_seen", 32'(tx_valid), 32'd1);
    end
    pulse_reset();
    check("pending_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("pending_rst_busy", 32'(busy), 32'd0);
    exp_frames = 16'd1;
    run_frame(vecs[0].b0, vecs[0].b1, vecs[0].exp, -1, 1'b0);

    // Frame counter wrap from 0xFFFF.
    @(negedge clk_emu);
    force dut_a.frame_cnt_q = 16'hFFFF;
    @(negedge clk_emu);
    release dut_a.frame_cnt_q;
    @(negedge clk_emu);
    check("preload_frame_cnt", 32'(frame_cnt), 32'hFFFF);
    exp_frames = 16'h0000;
    run_frame(vecs[1].b0, vecs[1].b1, vecs[1].exp, -1, 1'b0);

    run_half1_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
